// File: rtl/vanilla_scoreboard_stall_profiler_if.sv
// Signal bundle between the scoreboard stall profiler and its driver.
// slave: profiler side (scoreboard/ID/window controls in, counters out).
// master: driver side (the bench or the tracker wrapper).
interface vanilla_scoreboard_stall_profiler_if #(
    parameter int cnt_width_p = 32,
    parameter int reg_els_p   = 32
);
    logic [reg_els_p-1:0][5:0]   int_sb_i;
    logic [reg_els_p-1:0][3:0]   float_sb_i;
    logic                        stall_depend_i;
    logic                        stall_all_i;
    logic [4:0]                  id_rs1_i;
    logic [4:0]                  id_rs2_i;
    logic [4:0]                  id_rs3_i;
    logic [4:0]                  id_rd_i;
    logic [6:0]                  rd_mask_i;
    logic                        start_i;
    logic                        stop_i;
    logic [5:0][cnt_width_p-1:0] stall_cnt_o;
    logic [cnt_width_p-1:0]      max_run_o;
    logic                        snapshot_v_o;
    logic [1:0]                  state_o;

    modport slave (
        input  int_sb_i, float_sb_i, stall_depend_i, stall_all_i,
        input  id_rs1_i, id_rs2_i, id_rs3_i, id_rd_i, rd_mask_i,
        input  start_i, stop_i,
        output stall_cnt_o, max_run_o, snapshot_v_o, state_o
    );

    modport master (
        output int_sb_i, float_sb_i, stall_depend_i, stall_all_i,
        output id_rs1_i, id_rs2_i, id_rs3_i, id_rd_i, rd_mask_i,
        output start_i, stop_i,
        input  stall_cnt_o, max_run_o, snapshot_v_o, state_o
    );
endinterface

// File: rtl/vanilla_scoreboard_stall_profiler.sv
// Counts ID dependency-stall cycles by cause inside a start/stop window.
// Ports: clk_i, reset_n_i (async, active-low), prof (slave bundle).
module vanilla_scoreboard_stall_profiler #(
    parameter int cnt_width_p = 32,
    parameter int reg_els_p   = 32
) (
    input  logic clk_i,
    input  logic reset_n_i,
    vanilla_scoreboard_stall_profiler_if.slave prof
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_e;

    state_e state_r, state_n;

    logic [5:0][cnt_width_p-1:0] cnt_r;
    logic [cnt_width_p-1:0]      cur_run_r;
    logic [cnt_width_p-1:0]      max_run_r;
    logic [cnt_width_p-1:0]      run_inc;
    logic                        snap_r;

    logic       in_run;
    logic       counted;
    logic       clear;
    logic       snap_set;
    logic [5:0] ih;
    logic [3:0] fh;
    logic [2:0] cause;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (prof.start_i) state_n = RUN;
            RUN:     if (prof.stop_i)  state_n = HOLD;
            HOLD:    if (prof.start_i) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    // In RUN a simultaneous stop wins, so start only restarts when alone.
    always_comb begin
        in_run   = (state_r == RUN);
        counted  = in_run & prof.stall_depend_i & ~prof.stall_all_i;
        clear    = prof.start_i & ~(in_run & prof.stop_i);
        snap_set = in_run & prof.stop_i;
    end

    // Hit vectors; x0 is hardwired zero so it never carries a dependency.
    always_comb begin
        ih = '0;
        fh = '0;
        if (prof.rd_mask_i[0] && prof.id_rs1_i != 5'd0)
            ih = ih | prof.int_sb_i[prof.id_rs1_i];
        if (prof.rd_mask_i[1] && prof.id_rs2_i != 5'd0)
            ih = ih | prof.int_sb_i[prof.id_rs2_i];
        if (prof.rd_mask_i[5] && prof.id_rd_i != 5'd0)
            ih = ih | prof.int_sb_i[prof.id_rd_i];
        if (prof.rd_mask_i[2])
            fh = fh | prof.float_sb_i[prof.id_rs1_i];
        if (prof.rd_mask_i[3])
            fh = fh | prof.float_sb_i[prof.id_rs2_i];
        if (prof.rd_mask_i[4])
            fh = fh | prof.float_sb_i[prof.id_rs3_i];
        if (prof.rd_mask_i[6])
            fh = fh | prof.float_sb_i[prof.id_rd_i];
    end

    // Priority: dram > global > group > idiv > fdiv > unattributed.
    always_comb begin
        case (1'b1)
            ih[1] | ih[2] | fh[1]: cause = 3'd2;
            ih[3] | fh[2]:         cause = 3'd3;
            ih[4] | ih[5] | fh[3]: cause = 3'd4;
            ih[0]:                 cause = 3'd0;
            fh[0]:                 cause = 3'd1;
            default:               cause = 3'd5;
        endcase
    end

    assign run_inc = (cur_run_r == '1) ? cur_run_r : cur_run_r + 1'b1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r     <= '0;
            cur_run_r <= '0;
            max_run_r <= '0;
        end else if (clear) begin
            cnt_r     <= '0;
            cur_run_r <= '0;
            max_run_r <= '0;
        end else if (counted) begin
            for (int k = 0; k < 6; k++) begin
                if (cause == k[2:0] && cnt_r[k] != '1)
                    cnt_r[k] <= cnt_r[k] + 1'b1;
            end
            cur_run_r <= run_inc;
            if (run_inc > max_run_r) max_run_r <= run_inc;
        end else if (in_run) begin
            cur_run_r <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) snap_r <= 1'b0;
        else            snap_r <= snap_set;
    end

    assign prof.stall_cnt_o  = cnt_r;
    assign prof.max_run_o    = max_run_r;
    assign prof.snapshot_v_o = snap_r;
    assign prof.state_o      = state_r;
endmodule

// File: tb/tb_vanilla_scoreboard_stall_profiler.sv
// Bench for the scoreboard stall profiler: attribution table plus
// multi-cycle window, run-length, saturation and reset sequences.
module tb_vanilla_scoreboard_stall_profiler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vanilla_scoreboard_stall_profiler_if #(.cnt_width_p(32)) ifa ();
    vanilla_scoreboard_stall_profiler_if #(.cnt_width_p(4))  ifb ();

    vanilla_scoreboard_stall_profiler #(.cnt_width_p(32)) dut_w (
        .clk_i(clk), .reset_n_i(reset_n), .prof(ifa)
    );
    vanilla_scoreboard_stall_profiler #(.cnt_width_p(4)) dut_n (
        .clk_i(clk), .reset_n_i(reset_n), .prof(ifb)
    );

    assign ifb.int_sb_i       = ifa.int_sb_i;
    assign ifb.float_sb_i     = ifa.float_sb_i;
    assign ifb.stall_depend_i = ifa.stall_depend_i;
    assign ifb.stall_all_i    = ifa.stall_all_i;
    assign ifb.id_rs1_i       = ifa.id_rs1_i;
    assign ifb.id_rs2_i       = ifa.id_rs2_i;
    assign ifb.id_rs3_i       = ifa.id_rs3_i;
    assign ifb.id_rd_i        = ifa.id_rd_i;
    assign ifb.rd_mask_i      = ifa.rd_mask_i;
    assign ifb.start_i        = ifa.start_i;
    assign ifb.stop_i         = ifa.stop_i;

    typedef struct {
        logic [4:0] ireg;
        logic [5:0] ibits;
        logic [4:0] freg;
        logic [3:0] fbits;
        logic [4:0] rs1, rs2, rs3, rd;
        logic [6:0] mask;
        logic       dep, all;
        int         exp;
    } vec_t;

    typedef struct {
        logic [5:0][31:0] cnt;
        logic [31:0]      mx;
        string            name;
    } exp_t;

    vec_t vt[15];
    exp_t sbq[$];
    int nvec = 0;
    int nfail = 0;
    int snaps = 0;
    int s0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.snapshot_v_o === 1'b1) begin
            exp_t e;
            snaps++;
            if (sbq.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL snap_unexpected: got pulse expected none");
            end else begin
                e = sbq.pop_front();
                for (int k = 0; k < 6; k++)
                    chk($sformatf("%s cnt[%0d]", e.name, k),
                        ifa.stall_cnt_o[k], e.cnt[k]);
                chk({e.name, " max_run"}, ifa.max_run_o, e.mx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stim();
        ifa.int_sb_i       = '0;
        ifa.float_sb_i     = '0;
        ifa.stall_depend_i = 1'b0;
        ifa.stall_all_i    = 1'b0;
        ifa.id_rs1_i       = '0;
        ifa.id_rs2_i       = '0;
        ifa.id_rs3_i       = '0;
        ifa.id_rd_i        = '0;
        ifa.rd_mask_i      = '0;
    endtask

    task automatic set_vec(vec_t v);
        clr_stim();
        ifa.int_sb_i[v.ireg]   = v.ibits;
        ifa.float_sb_i[v.freg] = v.fbits;
        ifa.id_rs1_i       = v.rs1;
        ifa.id_rs2_i       = v.rs2;
        ifa.id_rs3_i       = v.rs3;
        ifa.id_rd_i        = v.rd;
        ifa.rd_mask_i      = v.mask;
        ifa.stall_depend_i = v.dep;
        ifa.stall_all_i    = v.all;
    endtask

    task automatic dram_stim();
        clr_stim();
        ifa.int_sb_i[5]    = 6'b000010;
        ifa.id_rs1_i       = 5'd5;
        ifa.rd_mask_i      = 7'b0000001;
        ifa.stall_depend_i = 1'b1;
    endtask

    task automatic push(int idx, int val, int mx, string n);
        exp_t e;
        e.cnt = '0;
        if (idx < 6) e.cnt[idx] = val;
        e.mx   = mx;
        e.name = n;
        sbq.push_back(e);
    endtask

    task automatic start_win();
        ifa.start_i = 1'b1;
        tick();
        ifa.start_i = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            ifa.stop_i = (i == n - 1);
            tick();
        end
        ifa.stop_i = 1'b0;
        clr_stim();
    endtask

    task automatic drain(string n);
        for (int i = 0; i < 4 && sbq.size() != 0; i++) tick();
        chk({n, " drain"}, sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{5'd5, 6'b000010, 5'd0, 4'b0000, 5'd5, 5'd0, 5'd0, 5'd0, 7'b0000001, 1, 0, 2};
        vt[1]  = '{5'd7, 6'b010001, 5'd0, 4'b0000, 5'd0, 5'd7, 5'd0, 5'd0, 7'b0000010, 1, 0, 4};
        vt[2]  = '{5'd0, 6'b000001, 5'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0000001, 1, 0, 5};
        vt[3]  = '{5'd0, 6'b000000, 5'd9, 4'b0001, 5'd0, 5'd0, 5'd9, 5'd0, 7'b0010000, 1, 0, 1};
        vt[4]  = '{5'd3, 6'b001000, 5'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd3, 7'b0100000, 1, 0, 3};
        vt[5]  = '{5'd3, 6'b001000, 5'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd3, 7'b0000011, 1, 0, 5};
        vt[6]  = '{5'd12, 6'b000001, 5'd12, 4'b0100, 5'd12, 5'd0, 5'd0, 5'd0, 7'b0000101, 1, 0, 3};
        vt[7]  = '{5'd0, 6'b000000, 5'd4, 4'b0010, 5'd0, 5'd0, 5'd0, 5'd4, 7'b1000000, 1, 0, 2};
        vt[8]  = '{5'd6, 6'b000100, 5'd6, 4'b0001, 5'd6, 5'd0, 5'd0, 5'd0, 7'b0000101, 1, 0, 2};
        vt[9]  = '{5'd8, 6'b100000, 5'd0, 4'b0000, 5'd0, 5'd8, 5'd0, 5'd0, 7'b0000010, 1, 0, 4};
        vt[10] = '{5'd5, 6'b000010, 5'd0, 4'b0000, 5'd5, 5'd0, 5'd0, 5'd0, 7'b0000001, 1, 1, 6};
        vt[11] = '{5'd5, 6'b000010, 5'd0, 4'b0000, 5'd5, 5'd0, 5'd0, 5'd0, 7'b0000001, 0, 0, 6};
        vt[12] = '{5'd10, 6'b000001, 5'd10, 4'b0001, 5'd10, 5'd10, 5'd0, 5'd0, 7'b0001001, 1, 0, 0};
        vt[13] = '{5'd0, 6'b000000, 5'd15, 4'b1000, 5'd0, 5'd15, 5'd0, 5'd0, 7'b0001000, 1, 0, 4};
        vt[14] = '{5'd0, 6'b000001, 5'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0100000, 1, 0, 5};

        clr_stim();
        ifa.start_i = 1'b0;
        ifa.stop_i  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 6; k++)
            chk($sformatf("reset cnt[%0d]", k), ifa.stall_cnt_o[k], 0);
        chk("reset max_run", ifa.max_run_o, 0);
        chk("reset state", ifa.state_o, 2'b00);
        chk("reset snapshot", ifa.snapshot_v_o, 0);

        start_win();
        chk("start state", ifa.state_o, 2'b01);
        dram_stim();
        push(2, 4, 4, "dram4");
        run(4);
        chk("stop state", ifa.state_o, 2'b10);
        tick();
        ifa.stall_depend_i = 1'b1;
        ifa.rd_mask_i      = 7'b0000001;
        ifa.int_sb_i[5]    = 6'b000010;
        ifa.id_rs1_i       = 5'd5;
        repeat (2) tick();
        clr_stim();
        drain("dram4");
        chk("hold frozen cnt[2]", ifa.stall_cnt_o[2], 4);
        chk("snapshot once", snaps, 1);

        start_win();
        clr_stim();
        ifa.int_sb_i[7]    = 6'b010001;
        ifa.id_rs2_i       = 5'd7;
        ifa.rd_mask_i      = 7'b0000010;
        ifa.stall_depend_i = 1'b1;
        push(4, 3, 3, "grp_over_idiv");
        run(3);
        tick();
        drain("grp_over_idiv");

        for (int i = 0; i < 15; i++) begin
            start_win();
            set_vec(vt[i]);
            push(vt[i].exp, 1, (vt[i].exp < 6) ? 1 : 0, $sformatf("vec%0d", i));
            ifa.stop_i = 1'b1;
            tick();
            ifa.stop_i = 1'b0;
            clr_stim();
            tick();
            drain($sformatf("vec%0d", i));
        end

        start_win();
        dram_stim();
        repeat (2) tick();
        ifa.stall_all_i = 1'b1;
        tick();
        ifa.stall_all_i = 1'b0;
        push(2, 5, 3, "run_break");
        run(3);
        tick();
        drain("run_break");

        start_win();
        dram_stim();
        repeat (2) tick();
        ifa.start_i = 1'b1;
        ifa.stop_i  = 1'b1;
        push(2, 3, 3, "stop_wins");
        tick();
        ifa.start_i = 1'b0;
        ifa.stop_i  = 1'b0;
        clr_stim();
        chk("stop_wins state", ifa.state_o, 2'b10);
        tick();
        drain("stop_wins");

        start_win();
        dram_stim();
        push(2, 20, 20, "sat_wide");
        run(20);
        tick();
        drain("sat_wide");
        chk("sat narrow cnt[2]", ifb.stall_cnt_o[2], 15);
        chk("sat narrow max_run", ifb.max_run_o, 15);

        start_win();
        chk("restart cnt[2]", ifa.stall_cnt_o[2], 0);
        chk("restart max_run", ifa.max_run_o, 0);
        chk("restart narrow cnt[2]", ifb.stall_cnt_o[2], 0);
        chk("restart state", ifa.state_o, 2'b01);

        dram_stim();
        repeat (2) tick();
        ifa.stop_i = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("async rst state", ifa.state_o, 2'b00);
        chk("async rst cnt[2]", ifa.stall_cnt_o[2], 0);
        s0 = snaps;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("idle stop ignored", ifa.state_o, 2'b00);
        ifa.stop_i = 1'b0;
        clr_stim();
        tick();
        chk("no snap on reset", snaps - s0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
